// File: rtl/fc_requant_pack.sv
// fc_requant_pack
// Requantizes a serial stream of signed accumulator sums (multiply by an
// unsigned scale, round-half-up right shift, signed saturation) and packs
// LENGTH results into one vector. The vector is handed to the next stage
// with a valid/ready handshake.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   element handshake
//   in_data             signed accumulator sum
//   scale_mult          unsigned multiplier, captured with each element
//   scale_shift         right shift, captured with each element
//   out_valid/out_ready vector handshake
//   out_data            packed signed vector, element 0 = first accepted
module fc_requant_pack #(
    parameter int BITWIDTH    = 8,
    parameter int LENGTH      = 1,
    parameter int ACC_WIDTH   = 24,
    parameter int MULT_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ACC_WIDTH-1:0]             in_data,
    input  logic [MULT_WIDTH-1:0]            scale_mult,
    input  logic [SHIFT_WIDTH-1:0]           scale_shift,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LENGTH-1:0][BITWIDTH-1:0]  out_data
);

    localparam int PW     = ACC_WIDTH + MULT_WIDTH + 1;
    localparam int CNT_W  = $clog2(LENGTH + 1);
    localparam int SLOT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    localparam logic [CNT_W-1:0]  LEN_C     = CNT_W'(LENGTH);
    localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(LENGTH - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LENGTH - 1);
    localparam logic [PW:0]       ONE       = (PW + 1)'(1);

    localparam logic signed [PW:0] SAT_MAX = {{(PW + 2 - BITWIDTH){1'b0}}, {(BITWIDTH - 1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN = {{(PW + 2 - BITWIDTH){1'b1}}, {(BITWIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {COLLECT, DRAIN, OUT} state_t;

    state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic accept;

    logic                   s0_valid;
    logic [ACC_WIDTH-1:0]   s0_data;
    logic [MULT_WIDTH-1:0]  s0_mult;
    logic [SHIFT_WIDTH-1:0] s0_shift;
    logic [SLOT_W-1:0]      s0_slot;

    logic                   s1_valid;
    logic signed [PW-1:0]   s1_prod;
    logic [SHIFT_WIDTH-1:0] s1_shift;
    logic [SLOT_W-1:0]      s1_slot;

    logic signed [PW-1:0]   prod_next;
    logic [PW:0]            round_bias;
    logic signed [PW:0]     biased;
    logic signed [PW:0]     rounded;
    logic [BITWIDTH-1:0]    sat_val;

    assign accept = in_valid && in_ready;

    // Next-state and handshake outputs. Collection stops once a full vector
    // has been accepted; DRAIN then waits until the last element sits in the
    // product stage, i.e. it lands in out_data on the same edge OUT is entered.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = !rst && (cnt < LEN_C);
                if (in_valid && in_ready && (cnt == LAST_C)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (s1_valid && (s1_slot == LAST_SLOT)) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // State register and element counter; the counter only clears when the
    // finished vector is consumed, so slots never overlap with the OUT phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= cnt + 1'b1;
            end else if ((state == OUT) && out_ready) begin
                cnt <= '0;
            end
        end
    end

    // Accepted element, its scale settings and its slot are captured together
    // so later changes of scale_* never affect elements already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
            s0_mult  <= '0;
            s0_shift <= '0;
            s0_slot  <= '0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_data  <= in_data;
                s0_mult  <= scale_mult;
                s0_shift <= scale_shift;
                s0_slot  <= cnt[SLOT_W-1:0];
            end
        end
    end

    // Signed x unsigned product: the multiplier is zero-extended so the
    // multiplication stays signed and the full-width result is exact.
    assign prod_next = $signed({{(MULT_WIDTH + 1){s0_data[ACC_WIDTH-1]}}, s0_data})
                     * $signed({{(ACC_WIDTH + 1){1'b0}}, s0_mult});

    // Product stage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_shift <= '0;
            s1_slot  <= '0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_prod  <= prod_next;
                s1_shift <= s0_shift;
                s1_slot  <= s0_slot;
            end
        end
    end

    // Round half up by adding half an LSB before the arithmetic shift; one
    // extra bit of headroom keeps the bias addition from overflowing.
    always_comb begin
        round_bias = '0;
        if (s1_shift != '0) begin
            round_bias = ONE << (s1_shift - 1'b1);
        end
        biased  = $signed({s1_prod[PW-1], s1_prod}) + $signed(round_bias);
        rounded = biased >>> s1_shift;
        if (rounded > SAT_MAX) begin
            sat_val = SAT_MAX[BITWIDTH-1:0];
        end else if (rounded < SAT_MIN) begin
            sat_val = SAT_MIN[BITWIDTH-1:0];
        end else begin
            sat_val = rounded[BITWIDTH-1:0];
        end
    end

    // Write-back into the vector; untouched slots keep their old contents
    // and out_valid alone qualifies the vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (s1_valid) begin
            out_data[s1_slot] <= sat_val;
        end
    end

endmodule

// File: tb/tb_fc_requant_pack.sv
// tb_fc_requant_pack
// Bench for fc_requant_pack: a LENGTH=4 instance exercised with a directed
// vector table, backpressure, reset and randomized vectors, and a LENGTH=1
// instance streamed with out_ready tied high. Expected element values come
// from an arithmetic reference model of the scaling rule.
module tb_fc_requant_pack;

    localparam int BW = 8;
    localparam int AW = 24;
    localparam int MW = 16;
    localparam int SW = 6;
    localparam int RAND_VECS = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              in_valid4 = 1'b0;
    logic              in_ready4;
    logic [AW-1:0]     in_data4 = '0;
    logic [MW-1:0]     mult4 = '0;
    logic [SW-1:0]     shift4 = '0;
    logic              out_valid4;
    logic              out_ready4 = 1'b0;
    logic [3:0][BW-1:0] out_data4;

    logic              in_valid1 = 1'b0;
    logic              in_ready1;
    logic [AW-1:0]     in_data1 = '0;
    logic [MW-1:0]     mult1 = '0;
    logic [SW-1:0]     shift1 = '0;
    logic              out_valid1;
    logic              out_ready1 = 1'b1;
    logic [0:0][BW-1:0] out_data1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vec4 = 0;
    logic ov4_prev = 1'b0;
    int q1[$];

    typedef struct {
        string name;
        int acc[4];
        int mult[4];
        int shift[4];
        int expv[4];
    } vec_t;

    vec_t tbl[3];

    fc_requant_pack #(.BITWIDTH(BW), .LENGTH(4), .ACC_WIDTH(AW), .MULT_WIDTH(MW), .SHIFT_WIDTH(SW)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .scale_mult(mult4), .scale_shift(shift4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
    );

    fc_requant_pack #(.BITWIDTH(BW), .LENGTH(1), .ACC_WIDTH(AW), .MULT_WIDTH(MW), .SHIFT_WIDTH(SW)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .scale_mult(mult1), .scale_shift(shift1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Count vectors presented by the LENGTH=4 instance (rising out_valid).
    always @(negedge clk) begin
        if (out_valid4 && !ov4_prev) vec4++;
        ov4_prev <= out_valid4;
    end

    // The LENGTH=1 instance has out_ready tied high, so every presented
    // vector is visible for exactly one cycle and is checked against the queue.
    always @(negedge clk) begin
        if (out_valid1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL l1_extra_vector: got %0d, expected no vector", $signed(out_data1[0]));
            end else begin
                checkOutput("l1_vector", $signed(out_data1[0]), q1.pop_front());
            end
        end
    end

    // Reference: full product, round half up via floor((p + 2^(s-1)) / 2^s), clamp.
    function automatic int refElem(input int acc, input int mult, input int shift);
        longint p, r, one, hi, lo;
        one = 1;
        hi = (one <<< (BW - 1)) - 1;
        lo = -(one <<< (BW - 1));
        p = longint'(acc) * longint'(mult);
        if (shift == 0) r = p;
        else r = (p + (one <<< (shift - 1))) >>> shift;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return int'(r);
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Offer one element to the LENGTH=4 instance after 'gap' idle cycles and
    // wait (bounded) until it is accepted.
    task automatic applyStimulus(input int acc, input int mult, input int shift, input int gap);
        repeat (gap) begin
            @(negedge clk);
            in_valid4 = 1'b0;
        end
        @(negedge clk);
        in_valid4 = 1'b1;
        in_data4  = acc[AW-1:0];
        mult4     = mult[MW-1:0];
        shift4    = shift[SW-1:0];
        for (int t = 0; t < 200 && !in_ready4; t++) @(negedge clk);
        checkOutput("accept4", in_ready4, 1);
        if (in_ready4) @(posedge clk);
        #1 in_valid4 = 1'b0;
    endtask

    // Same for the LENGTH=1 instance; reports the cycle of acceptance.
    task automatic applyStimulus1(input int acc, input int mult, input int shift, output int acc_cyc);
        @(negedge clk);
        in_valid1 = 1'b1;
        in_data1  = acc[AW-1:0];
        mult1     = mult[MW-1:0];
        shift1    = shift[SW-1:0];
        for (int t = 0; t < 200 && !in_ready1; t++) @(negedge clk);
        checkOutput("accept1", in_ready1, 1);
        if (in_ready1) @(posedge clk);
        #1 in_valid1 = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic checkVec4(input string name, input int expv[4]);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s[%0d]", name, i), $signed(out_data4[i]), expv[i]);
        end
    endtask

    // Bounded wait for out_valid on the LENGTH=4 instance.
    task automatic waitOut4(input string name);
        for (int t = 0; t < 200 && !out_valid4; t++) @(negedge clk);
        checkOutput({name, "_out_valid"}, out_valid4, 1);
    endtask

    // Consume the presented vector and verify the handshake release timing.
    task automatic handshake4(input string name);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1 out_ready4 = 1'b0;
        @(negedge clk);
        checkOutput({name, "_valid_drop"}, out_valid4, 0);
        checkOutput({name, "_ready_back"}, in_ready4, 1);
    endtask

    initial begin
        int expv[4];
        int a, m, s, c_prev, c_now, vec_start;
        logic [3:0][BW-1:0] held;

        tbl[0].name = "basic";
        tbl[0].acc = '{1000, 1004, -1004, 0};
        tbl[0].mult = '{1, 1, 1, 1};
        tbl[0].shift = '{3, 3, 3, 3};
        tbl[0].expv = '{125, 126, -125, 0};
        tbl[1].name = "saturate";
        tbl[1].acc = '{5000, -5000, 1023, -1025};
        tbl[1].mult = '{1, 1, 1, 1};
        tbl[1].shift = '{3, 3, 3, 3};
        tbl[1].expv = '{127, -128, 127, -128};
        tbl[2].name = "per_elem_scale";
        tbl[2].acc = '{100, -7, 1, -1};
        tbl[2].mult = '{3, 1, 65535, 65535};
        tbl[2].shift = '{2, 0, 16, 16};
        tbl[2].expv = '{75, -7, 1, -1};

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", in_ready4, 0);
        checkOutput("reset_out_valid", out_valid4, 0);
        checkOutput("reset_out_data", out_data4, 0);
        rst = 1'b0;
        #1;
        checkOutput("release_in_ready", in_ready4, 1);
        checkOutput("release_in_ready_l1", in_ready1, 1);

        // Directed table: latency, values, handshake.
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 4; i++) begin
                applyStimulus(tbl[v].acc[i], tbl[v].mult[i], tbl[v].shift[i], 0);
            end
            @(negedge clk);
            checkOutput({tbl[v].name, "_lat1"}, out_valid4, 0);
            @(negedge clk);
            checkOutput({tbl[v].name, "_lat2"}, out_valid4, 0);
            @(negedge clk);
            checkOutput({tbl[v].name, "_lat3"}, out_valid4, 1);
            checkVec4(tbl[v].name, tbl[v].expv);
            handshake4(tbl[v].name);
        end

        // Backpressure: vector held for 10 cycles with out_ready low.
        for (int i = 0; i < 4; i++) begin
            expv[i] = refElem(300 * (i + 1) - 700, 2, 4);
            applyStimulus(300 * (i + 1) - 700, 2, 4, 0);
        end
        in_valid4 = 1'b1;
        waitOut4("bp");
        held = out_data4;
        checkVec4("bp", expv);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            checkOutput("bp_valid_hold", out_valid4, 1);
            checkOutput("bp_data_hold", out_data4, held);
            checkOutput("bp_in_ready_low", in_ready4, 0);
        end
        in_valid4 = 1'b0;
        handshake4("bp");

        // Randomized vectors with input bubbles and random output stalls.
        vec_start = vec4;
        for (int v = 0; v < RAND_VECS; v++) begin
            for (int i = 0; i < 4; i++) begin
                a = $signed($urandom) >>> 8;
                m = int'($urandom_range(0, 65535));
                s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 39)) : int'($urandom_range(10, 22));
                expv[i] = refElem(a, m, s);
                applyStimulus(a, m, s, int'($urandom_range(0, 3)));
            end
            waitOut4("rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checkVec4($sformatf("rand_v%0d", v), expv);
            handshake4("rand");
        end
        checkOutput("rand_vector_count", vec4 - vec_start, RAND_VECS);

        // Reset after two of four accepts: nothing emitted, slots cleared.
        applyStimulus(800, 1, 3, 0);
        applyStimulus(-800, 1, 3, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready", in_ready4, 0);
        checkOutput("midrst_data_clear", out_data4, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_release_ready", in_ready4, 1);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            checkOutput("midrst_no_valid", out_valid4, 0);
            checkOutput("midrst_no_write", out_data4, 0);
        end
        for (int i = 0; i < 4; i++) begin
            expv[i] = refElem(16 * i + 8, 1, 4);
            applyStimulus(16 * i + 8, 1, 4, 0);
        end
        waitOut4("midrst_clean");
        checkVec4("midrst_clean", expv);
        handshake4("midrst_clean");
        checkOutput("total_vector_count", vec4, 3 + 1 + RAND_VECS + 1);

        // LENGTH=1 instance: directed element, then back-to-back stream.
        q1.push_back(126);
        applyStimulus1(1004, 1, 3, c_prev);
        @(negedge clk);
        checkOutput("l1_lat1", out_valid1, 0);
        @(negedge clk);
        checkOutput("l1_lat2", out_valid1, 0);
        @(negedge clk);
        checkOutput("l1_lat3", out_valid1, 1);
        for (int n = 0; n < 6; n++) begin
            a = $signed($urandom) >>> 12;
            m = int'($urandom_range(0, 300));
            s = int'($urandom_range(0, 14));
            q1.push_back(refElem(a, m, s));
            applyStimulus1(a, m, s, c_now);
            checkOutput("l1_spacing", c_now - c_prev, 4);
            c_prev = c_now;
        end
        for (int t = 0; t < 20 && q1.size() > 0; t++) @(negedge clk);
        checkOutput("l1_queue_empty", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_requant_pack.md
# fc_requant_pack

Requantization and vector-assembly stage at the output of the fully connected layer's accumulator. Accepts a serial stream of wide signed dot-product sums, scales each by a runtime multiplier and right shift with round-half-up and signed saturation, and packs LENGTH results into a parallel vector. The vector is presented with a valid/ready handshake directly to the vector ReLU stage that follows.

## Interface
Parameters:
- BITWIDTH, 8, output element width (signed), matches the ReLU stage input width
- LENGTH, 1, elements per output vector
- ACC_WIDTH, 24, signed accumulator input width
- MULT_WIDTH, 16, unsigned scale multiplier width
- SHIFT_WIDTH, 6, scale shift width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_data/scale_* valid
- in_ready  out  1  block accepts an element this cycle
- in_data  in  ACC_WIDTH  signed accumulator sum
- scale_mult  in  MULT_WIDTH  unsigned multiplier, sampled with each accepted element
- scale_shift  in  SHIFT_WIDTH  right shift, 0..ACC_WIDTH+MULT_WIDTH-1, sampled with each element
- out_valid  out  1  out_data holds a complete vector
- out_ready  in  1  downstream consumes vector
- out_data  out  BITWIDTH x [LENGTH-1:0]  signed packed vector; element 0 = first accepted

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Stage 1 (registered): product = signed(in_data) * unsigned(scale_mult), full ACC_WIDTH+MULT_WIDTH+1 bits, plus registered shift and slot index.
- Stage 2 (registered into out_data[slot]): if shift=0, r = product; else r = (product + 2^(shift-1)) >>> shift (arithmetic). Saturate r to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
- Counter cnt (0..LENGTH) counts accepted elements of current vector; slot = cnt at acceptance.
- States:
  - COLLECT: in_ready = (cnt < LENGTH). On acceptance of element LENGTH-1 go to DRAIN.
  - DRAIN: in_ready=0; waits for the last element to be written by stage 2; then OUT.
  - OUT: out_valid=1, in_ready=0, out_data stable. On out_ready: cnt<=0, out_valid<=0, go to COLLECT.
- out_data retains last vector after handshake until slots are overwritten; only out_valid qualifies it.
- in_valid gaps allowed at any point; the pipeline advances every cycle regardless.
- LENGTH=1: each element goes COLLECT→DRAIN→OUT.
- scale_mult/scale_shift may change per element; no effect on elements already accepted.

## Timing
- Reset (async assert, sync-safe deassert): state=COLLECT, cnt=0, pipeline valids=0, out_valid=0, out_data all 0. in_ready=0 while rst high, 1 in first cycle after release.
- Latency: last element accepted at edge E → product at E+1 → slot written and out_valid=1 after edge E+2.
- Min period per vector: LENGTH accept cycles + 2 pipeline cycles + 1 handshake cycle (no overlap of collection with OUT).
- out_valid, once high, stays high with out_data unchanged until the edge where out_ready=1.
- out_ready while out_valid=0: ignored.
- rst mid-vector: partial vector discarded, in-flight pipeline entries dropped, nothing emitted.
- in_valid while in_ready=0: not accepted; upstream must hold data.

## Test plan
- BITWIDTH=8, LENGTH=4, mult=1, shift=3, inputs 1000,1004,-1004,0 → one vector {125,126,-125,0}, out_valid 2 cycles after 4th accept.
- Saturation: mult=1, shift=3, inputs 5000,-5000,1023,-1025 → {127,-128,127,-128}; mult=3, shift=2, input 100 → 75; shift=0, mult=1, input -7 → -7.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_data and out_valid stable, in_ready=0 throughout; out_ready=1 → out_valid drops next edge, in_ready=1 next cycle.
- Bubbles: random in_valid gaps over 3 vectors → element ordering preserved, vector count = 3, no extra/lost elements.
- Reset mid-vector: assert rst after 2 of 4 accepts → out_valid stays 0, out_data all 0; next 4 inputs form a clean vector in slots 0..3.
- LENGTH=1 build: stream 1004 (shift 3) → out_valid with {126}; back-to-back vectors spaced ≥4 cycles with out_ready tied 1.
